// File: rtl/xbee_msg_tx.sv
// xbee_msg_tx: serialises an NUM_BYTES-character ASCII status message onto
// the XBee UART line (8N1, most-significant character first, LSB-first
// within each character). A falling edge on the active-low `flag` starts a
// message. `busy` covers the whole frame and `done` pulses once at the end.
//
// Optional feature, macro XBEE_TERM_STOP_EN: when defined, the message ends
// after the stop bit of the first '#' (0x23) character even if bytes remain.
// When undefined, every character is sent and '#' is ordinary data.
module xbee_msg_tx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int NUM_BYTES    = 8,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic                   clk_50M,
    input  logic                   rst_n,
    input  logic                   flag,
    input  logic [8*NUM_BYTES-1:0] data,
    output logic                   tx,
    output logic                   busy,
    output logic                   done
);

    localparam int MSG_W  = 8 * NUM_BYTES;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = $clog2(NUM_BYTES) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg,  baud_next;
    logic [2:0]        bit_reg,   bit_next;
    logic [BYTE_W-1:0] byte_reg,  byte_next;
    logic [MSG_W-1:0]  msg_reg,   msg_next;
    logic              tx_reg,    tx_next;
    logic              busy_reg,  busy_next;
    logic              done_reg,  done_next;
    logic              flag_q_reg;

    logic              request;
    logic              baud_last;
    logic              term_hit;
    logic [7:0]        next_byte;

    // A request is a high-to-low transition of flag between two samples.
    assign request   = flag_q_reg && !flag;
    assign baud_last = (baud_reg == BAUD_LAST);

`ifdef XBEE_TERM_STOP_EN
    // The character currently on the line is always the top byte of msg_reg.
    assign term_hit = (msg_reg[MSG_W-1 -: 8] == 8'h23);
`else
    assign term_hit = 1'b0;
`endif

    // State register plus registered line outputs; reset forces an idle line.
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            byte_reg   <= '0;
            msg_reg    <= '0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            flag_q_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            byte_reg   <= byte_next;
            msg_reg    <= msg_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            flag_q_reg <= flag;
        end
    end

    // Next-state, counters and shift register; outputs are derived from the
    // state being entered so they appear on the same edge as the state.
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        byte_next  = byte_reg;
        msg_next   = msg_reg;

        case (state_reg)
            IDLE: begin
                if (request) begin
                    msg_next   = data;
                    state_next = START;
                    baud_next  = '0;
                    bit_next   = '0;
                    byte_next  = '0;
                end
            end

            START: begin
                if (baud_last) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end

            DATA: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end

            STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    if ((byte_reg == BYTE_LAST) || term_hit) begin
                        state_next = DONE;
                    end else begin
                        // Next character moves to the top; no inter-byte gap.
                        byte_next  = byte_reg + BYTE_W'(1);
                        msg_next   = msg_reg << 8;
                        bit_next   = '0;
                        state_next = START;
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end

            DONE: begin
                // Requests arriving here are deliberately dropped.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line level, busy and done for the state about to be entered.
    always_comb begin
        next_byte = msg_next[MSG_W-1 -: 8];
        tx_next   = 1'b1;
        busy_next = 1'b0;
        done_next = 1'b0;

        case (state_next)
            START: begin
                tx_next   = 1'b0;
                busy_next = 1'b1;
            end
            DATA: begin
                tx_next   = next_byte[bit_next];
                busy_next = 1'b1;
            end
            STOP: begin
                tx_next   = 1'b1;
                busy_next = 1'b1;
            end
            DONE: begin
                done_next = 1'b1;
            end
            default: begin
                tx_next = 1'b1;
            end
        endcase
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule
